// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio SRAM sample buffer.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned ADDR_W_DEF = 18;
  localparam logic [ADDR_W_DEF-1:0] ADDR_MAX_DEF = 18'h3FFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REC_WAIT  = 3'd1,
    ST_REC_WR    = 3'd2,
    ST_PLAY_WAIT = 3'd3,
    ST_PLAY_RD1  = 3'd4,
    ST_PLAY_RD2  = 3'd5
  } state_e;

endpackage

// File: rtl/sram_port.sv
// Registered control/address outputs and tristate data driver for the async SRAM.
module sram_port
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we_i,
  input  logic                oe_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  output logic [SAMPLE_W-1:0] rdata_o,
  output logic [ADDR_W-1:0]   sram_addr,
  inout  wire  [SAMPLE_W-1:0] sram_dq,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n
);

  logic [ADDR_W-1:0]   addr_q;
  logic [SAMPLE_W-1:0] wdata_q;
  logic                we_n_q;
  logic                oe_n_q;
  logic                dq_en_q;

  // Controls follow the controller's next state so they line up with its state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      dq_en_q <= 1'b0;
    end else begin
      addr_q  <= addr_i;
      we_n_q  <= ~we_i;
      oe_n_q  <= ~oe_i;
      dq_en_q <= we_i;
      if (we_i) wdata_q <= wdata_i;
    end
  end

  assign sram_dq   = dq_en_q ? wdata_q : {SAMPLE_W{1'bz}};
  assign rdata_o   = sram_dq;
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: rtl/audio_sram_ctrl.sv
// Record/playback controller buffering codec samples in a 256K x 16 async SRAM.
// Define AUDIO_LOOP_PLAY_EN to make playback wrap to address 0 instead of stopping.
module audio_sram_ctrl
  import audio_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(ADDR_MAX_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                record,
  input  logic                play,
  input  logic                stop,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                dac_req,
  output logic [SAMPLE_W-1:0] dac_data,
  output logic [ADDR_W-1:0]   sram_addr,
  inout  wire  [SAMPLE_W-1:0] sram_dq,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n,
  output logic [ADDR_W-1:0]   end_addr,
  output logic                full,
  output logic                done,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
  logic                full_q, full_d;
  logic                done_q, done_d;
  logic                busy_q;
  logic                recorded_q, recorded_d;
  logic [SAMPLE_W-1:0] dac_data_q, dac_data_d;
  logic                hold_vld_q, hold_vld_d;
  logic [SAMPLE_W-1:0] hold_data_q, hold_data_d;
  logic [SAMPLE_W-1:0] wdata_d;
  logic [SAMPLE_W-1:0] rdata_c;
  logic                we_d, oe_d;

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    end_addr_d  = end_addr_q;
    full_d      = full_q;
    done_d      = 1'b0;
    recorded_d  = recorded_q;
    dac_data_d  = dac_data_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    wdata_d     = hold_data_q;

    case (state_q)
      ST_IDLE: begin
        hold_vld_d = 1'b0;
        if (record) begin
          state_d = ST_REC_WAIT;
          addr_d  = '0;
          full_d  = 1'b0;
        end else if (play) begin
          state_d = ST_PLAY_WAIT;
          addr_d  = '0;
        end
      end

      ST_REC_WAIT: begin
        if (stop || !record) begin
          state_d    = ST_IDLE;
          hold_vld_d = 1'b0;
        end else if (hold_vld_q) begin
          // Service the sample captured during the previous write first.
          state_d     = ST_REC_WR;
          wdata_d     = hold_data_q;
          hold_vld_d  = sample_valid;
          hold_data_d = sample_valid ? adc_data : hold_data_q;
        end else if (sample_valid) begin
          state_d = ST_REC_WR;
          wdata_d = adc_data;
        end
      end

      ST_REC_WR: begin
        end_addr_d = addr_q;
        recorded_d = 1'b1;
        if (sample_valid && !hold_vld_q) begin
          hold_vld_d  = 1'b1;
          hold_data_d = adc_data;
        end
        if (addr_q == ADDR_MAX) begin
          full_d     = 1'b1;
          state_d    = ST_IDLE;
          hold_vld_d = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (stop) begin
            state_d    = ST_IDLE;
            hold_vld_d = 1'b0;
          end else begin
            state_d = ST_REC_WAIT;
          end
        end
      end

      ST_PLAY_WAIT: begin
        if (stop || !play) begin
          state_d = ST_IDLE;
        end else if (!recorded_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (dac_req) begin
          state_d = ST_PLAY_RD1;
        end
      end

      ST_PLAY_RD1: begin
        state_d = stop ? ST_IDLE : ST_PLAY_RD2;
      end

      ST_PLAY_RD2: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          dac_data_d = rdata_c;
          if (addr_q == end_addr_q) begin
            done_d = 1'b1;
`ifdef AUDIO_LOOP_PLAY_EN
            addr_d  = '0;
            state_d = ST_PLAY_WAIT;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_PLAY_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_d = (state_d == ST_REC_WR);
    oe_d = (state_d == ST_PLAY_RD1) || (state_d == ST_PLAY_RD2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      end_addr_q  <= '0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      recorded_q  <= 1'b0;
      dac_data_q  <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      end_addr_q  <= end_addr_d;
      full_q      <= full_d;
      done_q      <= done_d;
      busy_q      <= (state_d != ST_IDLE);
      recorded_q  <= recorded_d;
      dac_data_q  <= dac_data_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  sram_port #(
    .ADDR_W (ADDR_W)
  ) u_sram_port (
    .clk       (clk),
    .reset     (reset),
    .we_i      (we_d),
    .oe_i      (oe_d),
    .addr_i    (addr_d),
    .wdata_i   (wdata_d),
    .rdata_o   (rdata_c),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  assign dac_data = dac_data_q;
  assign end_addr = end_addr_q;
  assign full     = full_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_audio_sram_ctrl.sv
// Bench for audio_sram_ctrl: SRAM models, directed and randomized record/playback.
module tb_audio_sram_ctrl;

  localparam int unsigned AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, record, play, stop, sample_valid, dac_req;
  logic          record_s, play_s;
  logic [15:0]   adc_data;

  logic [15:0]   dac0, dac1;
  logic [AW-1:0] a0, a1, end0, end1;
  wire  [15:0]   dq0, dq1;
  logic          ce0, oe0, we0, ub0, lb0, full0, done0, busy0;
  logic          ce1, oe1, we1, ub1, lb1, full1, done1, busy1;

  audio_sram_ctrl dut (
    .clk(clk), .reset(reset), .record(record), .play(play), .stop(stop),
    .sample_valid(sample_valid), .adc_data(adc_data), .dac_req(dac_req),
    .dac_data(dac0), .sram_addr(a0), .sram_dq(dq0),
    .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0), .sram_ub_n(ub0), .sram_lb_n(lb0),
    .end_addr(end0), .full(full0), .done(done0), .busy(busy0)
  );

  audio_sram_ctrl #(.ADDR_MAX(18'd3)) dut_s (
    .clk(clk), .reset(reset), .record(record_s), .play(play_s), .stop(stop),
    .sample_valid(sample_valid), .adc_data(adc_data), .dac_req(dac_req),
    .dac_data(dac1), .sram_addr(a1), .sram_dq(dq1),
    .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1), .sram_ub_n(ub1), .sram_lb_n(lb1),
    .end_addr(end1), .full(full1), .done(done1), .busy(busy1)
  );

  // Asynchronous SRAM models with write logs and read-cycle counters.
  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];
  logic [33:0] wlog0 [$];
  logic [33:0] wlog1 [$];
  int          oe_cnt0 = 0;

  assign dq0 = (!ce0 && !oe0 && we0) ? mem0[a0[9:0]] : 16'bz;
  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[a1[9:0]] : 16'bz;

  always @(posedge clk) begin
    if (!ce0 && !we0) begin
      mem0[a0[9:0]] <= dq0;
      wlog0.push_back({a0, dq0});
    end
    if (!ce1 && !we1) begin
      mem1[a1[9:0]] <= dq1;
      wlog1.push_back({a1, dq1});
    end
    if (!oe0) oe_cnt0++;
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  logic [15:0] prev_dac = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d);
    sample_valid = 1'b1;
    adc_data     = d;
    cyc(1);
    sample_valid = 1'b0;
  endtask

  // Every accepted sample lands at the next address in arrival order.
  task automatic check_rec0();
    chk("wr_count", 32'(wlog0.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog0.size(); i++) begin
      chk("wr_addr", 32'(wlog0[i][33:16]), 32'(i));
      chk("wr_data", 32'(wlog0[i][15:0]), 32'(exp_q[i]));
    end
    chk("end_addr", 32'(end0), 32'(exp_q.size() - 1));
    chk("full_clear", 32'(full0), 32'd0);
    chk("rec_idle", 32'(busy0), 32'd0);
  endtask

  task automatic rec_random(input int n);
    logic [15:0] d;
    bit          b2b;
    int          gap;
    exp_q.delete();
    wlog0.delete();
    b2b    = 1'b0;
    record = 1'b1;
    cyc(1);
    for (int i = 0; i < n; i++) begin
      d = 16'($urandom);
      exp_q.push_back(d);
      send(d);
      if (b2b) begin
        gap = $urandom_range(2, 3);
        b2b = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        gap = 0;
        b2b = 1'b1;
      end else begin
        gap = $urandom_range(1, 3);
      end
      cyc(gap);
    end
    cyc(4);
    record = 1'b0;
    cyc(1);
    check_rec0();
  endtask

  // Reads come back in recorded order, 3 clocks after each request.
  task automatic play_check(input int reads);
    int          n;
    int          idx;
    logic [15:0] expv;
    n       = exp_q.size();
    oe_cnt0 = 0;
    play    = 1'b1;
    cyc(1);
    for (int i = 0; i < reads; i++) begin
`ifdef AUDIO_LOOP_PLAY_EN
      idx = i % n;
`else
      idx = i;
`endif
      expv    = exp_q[idx];
      dac_req = 1'b1;
      cyc(1);
      dac_req = 1'b0;
      cyc(1);
      chk("dac_early", 32'(dac0), 32'(prev_dac));
      cyc(1);
      chk("dac_data", 32'(dac0), 32'(expv));
      chk("done", 32'(done0), 32'(idx == n - 1));
      prev_dac = expv;
      if (i == reads - 1) play = 1'b0;
      else cyc($urandom_range(0, 2));
    end
    cyc(1);
    chk("play_idle", 32'(busy0), 32'd0);
    chk("oe_cycles", 32'(oe_cnt0), 32'(2 * reads));
  endtask

  initial begin
    reset = 1'b0; record = 1'b0; play = 1'b0; stop = 1'b0;
    sample_valid = 1'b0; dac_req = 1'b0; adc_data = 16'h0;
    record_s = 1'b0; play_s = 1'b0;
    cyc(3);

    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_end", 32'(end0), 32'd0);
    chk("rst_dac", 32'(dac0), 32'd0);
    chk("rst_addr", 32'(a0), 32'd0);
    chk("rst_we", 32'(we0), 32'd1);
    chk("rst_oe", 32'(oe0), 32'd1);
    chk("rst_ctl", 32'({ce0, ub0, lb0, ce1, ub1, lb1}), 32'd0);
    reset = 1'b1;
    cyc(2);

    // Playback with nothing recorded ends immediately with done.
    play = 1'b1;
    cyc(1);
    chk("empty_busy", 32'(busy0), 32'd1);
    cyc(1);
    chk("empty_done", 32'(done0), 32'd1);
    play = 1'b0;
    cyc(1);
    chk("empty_idle", 32'({busy0, done0}), 32'd0);

    // Reset asserted in the middle of a write cycle.
    record = 1'b1;
    cyc(1);
    send(16'hABCD);
    chk("midwr_we", 32'(we0), 32'd0);
    chk("midwr_dq", 32'(dq0), 32'hABCD);
    reset = 1'b0;
    #1;
    chk("rstwr_we", 32'(we0), 32'd1);
    chk("rstwr_busy", 32'(busy0), 32'd0);
    chk("rstwr_end", 32'(end0), 32'd0);
    cyc(1);
    record = 1'b0;
    reset  = 1'b1;
    cyc(1);

    // Directed 4-word record and playback.
    wlog0.delete();
    exp_q.delete();
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);
    record = 1'b1;
    cyc(1);
    foreach (exp_q[i]) begin
      send(exp_q[i]);
      cyc(1);
    end
    cyc(3);
    record = 1'b0;
    cyc(1);
    check_rec0();
    play_check(4);

    // record has priority over play; stop aborts playback waiting.
    wlog0.delete();
    oe_cnt0 = 0;
    record  = 1'b1;
    play    = 1'b1;
    cyc(1);
    chk("both_busy", 32'(busy0), 32'd1);
    send(16'h5A5A);
    cyc(2);
    chk("both_wr_cnt", 32'(wlog0.size()), 32'd1);
    chk("both_wr", 32'(wlog0.size() > 0 ? wlog0[0] : 34'h0), 32'(34'h5A5A));
    chk("both_no_rd", 32'(oe_cnt0), 32'd0);
    record = 1'b0;
    play   = 1'b0;
    cyc(1);
    play = 1'b1;
    cyc(1);
    chk("pw_busy", 32'(busy0), 32'd1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    play = 1'b0;
    chk("stop_idle", 32'(busy0), 32'd0);
    oe_cnt0 = 0;
    dac_req = 1'b1;
    cyc(1);
    dac_req = 1'b0;
    cyc(4);
    chk("stop_no_rd", 32'(oe_cnt0), 32'd0);

    // Small instance: ADDR_MAX=3, six samples offered, only four written.
    wlog1.delete();
    record_s = 1'b1;
    cyc(1);
    for (int k = 0; k < 6; k++) begin
      send(16'h0A00 + 16'(k));
      if (k == 3) record_s = 1'b0;
      cyc(1);
    end
    cyc(2);
    chk("max_wr_cnt", 32'(wlog1.size()), 32'd4);
    for (int k = 0; k < 4 && k < wlog1.size(); k++)
      chk("max_wr", 32'(wlog1[k]), 32'({18'(k), 16'h0A00 + 16'(k)}));
    chk("max_full", 32'(full1), 32'd1);
    chk("max_idle", 32'(busy1), 32'd0);
    chk("max_end", 32'(end1), 32'd3);

`ifdef AUDIO_LOOP_PLAY_EN
    rec_random(2);
    play_check(5);
`endif

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 8);
      rec_random(n);
      play_check(n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
